// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
//   - FSM state encoding (IDLE, ISSUE, WAIT)
//   - grant owner encoding (OWN_IF, OWN_DM)
//   - ABORT_DATA: read data returned to the owner when a transaction times out
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_timeout_timer.sv
// Transaction watchdog for the memory arbiter.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count from zero (held while the arbiter is idle)
//   run       - count this cycle (arbiter is in ISSUE or WAIT)
//   expired   - running and the count has reached TIMEOUT-1
// The count parks at TIMEOUT-1, so a transaction that is still pending on
// the cycle after a deadline (e.g. mem_ready won the deadline cycle and the
// arbiter moved on to WAIT) expires at the next opportunity instead of
// wrapping around.
module mem_arb_timeout_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] timer;

  assign expired = run & (timer == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (run && (timer != LAST)) begin
      timer <= timer + W'(1);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch stage
// (IF port) and the memory stage (DM port). One transaction is outstanding
// at a time; completion is reported by a one-cycle valid pulse per port.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   if_req/if_addr                   - fetch request (held until if_valid)
//   if_rdata/if_valid/stall_f        - fetch result, completion pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata    - load/store request (held until dm_valid)
//   dm_rdata/dm_valid/stall_m        - load result, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata- request to memory, held until mem_ready
//   mem_ready/mem_rvalid/mem_rdata   - memory accept, response, read data
//   mem_err                          - sticky timeout flag
//
// state | meaning
// IDLE  | no transaction; arbitrate between eligible ports
// ISSUE | mem_req asserted, waiting for mem_ready
// WAIT  | request accepted, waiting for mem_rvalid
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_f,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_m,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(ABORT_DATA);

  logic [1:0] state;
  logic       grantOwner;
  logic [3:0] starveCnt;
  logic       ifEligible;
  logic       dmEligible;
  logic       ifWins;
  logic       dmWins;
  logic       timerExpired;
  logic       txnDone;
  logic       txnAbort;

  // A port whose valid is pulsing this cycle has already been served;
  // its req is still the old one, so it must not be granted again.
  assign ifEligible = if_req & ~if_valid;
  assign dmEligible = dm_req & ~dm_valid;

  assign ifWins = ifEligible & (~dmEligible | (starveCnt == STARVE_LIM));
  assign dmWins = dmEligible & ~ifWins;

  assign stall_f = if_req & ~if_valid;
  assign stall_m = dm_req & ~dm_valid;

  // mem_ready / mem_rvalid take priority over a coinciding deadline.
  assign txnDone  = (state == WAIT) & mem_rvalid;
  assign txnAbort = timerExpired &
                    (((state == ISSUE) & ~mem_ready) | ((state == WAIT) & ~mem_rvalid));

  mem_arb_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) uTimer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .run     ((state == ISSUE) | (state == WAIT)),
    .expired (timerExpired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grantOwner <= OWN_IF;
      starveCnt  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_err    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (ifWins || dmWins) begin
            mem_req    <= 1'b1;
            grantOwner <= dmWins ? OWN_DM : OWN_IF;
            mem_we     <= dmWins & dm_we;
            mem_addr   <= dmWins ? dm_addr : if_addr;
            mem_wdata  <= dmWins ? dm_wdata : '0;
            state      <= ISSUE;
            if (ifWins || !ifEligible) begin
              starveCnt <= '0;
            end else if (starveCnt != STARVE_LIM) begin
              starveCnt <= starveCnt + 4'd1;
            end
          end
        end

        ISSUE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end

        WAIT: ;

        default: state <= IDLE;
      endcase

      if (txnDone || txnAbort) begin
        state   <= IDLE;
        mem_req <= 1'b0;
        if (txnAbort) begin
          mem_err <= 1'b1;
        end
        if (grantOwner == OWN_IF) begin
          if_valid <= 1'b1;
          if_rdata <= txnAbort ? ABORT_WORD : mem_rdata;
        end else begin
          dm_valid <= 1'b1;
          // Completed stores leave dm_rdata alone; aborted ones report the marker.
          if (txnAbort) begin
            dm_rdata <= ABORT_WORD;
          end else if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        stall_f;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        stall_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_err;

  int vecCount = 0;
  int missCount = 0;

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .stall_f(stall_f),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory responder: accept in ISSUE, answer in WAIT. Call in the IDLE cycle
  // in which the grant happens; returns in the cycle the valid pulse is visible,
  // with the request as registered on the memory side.
  task automatic serve(input logic [31:0] rd, output logic we, output logic [31:0] addr,
                       output logic [31:0] wd);
    mem_ready = 1'b1;
    tick();
    we = mem_we;
    addr = mem_addr;
    wd = mem_wdata;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vecCount++; if (mem_req !== 1'b0) begin missCount++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    vecCount++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin missCount++; $display("FAIL reset_valid got %b%b want 00", if_valid, dm_valid); end
    vecCount++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin missCount++; $display("FAIL reset_rdata got %h %h want 0 0", if_rdata, dm_rdata); end
    vecCount++; if (mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_err !== 1'b0) begin missCount++; $display("FAIL reset_mem_side got addr %h we %b err %b want 0", mem_addr, mem_we, mem_err); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_if_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0010; mem_ready = 1'b1;
    #1;
    vecCount++; if (stall_f !== 1'b1) begin missCount++; $display("FAIL fetch_stall_c0 got %b want 1", stall_f); end
    tick();
    vecCount++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin missCount++; $display("FAIL fetch_issue got req %b addr %h we %b want 1 10 0", mem_req, mem_addr, mem_we); end
    vecCount++; if (stall_f !== 1'b1) begin missCount++; $display("FAIL fetch_stall_c1 got %b want 1", stall_f); end
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0093;
    vecCount++; if (mem_req !== 1'b0 || stall_f !== 1'b1 || if_valid !== 1'b0) begin missCount++; $display("FAIL fetch_wait got req %b stall %b valid %b want 0 1 0", mem_req, stall_f, if_valid); end
    tick();
    mem_rvalid = 1'b0;
    #1;
    vecCount++; if (if_valid !== 1'b1 || if_rdata !== 32'h93) begin missCount++; $display("FAIL fetch_valid got %b %h want 1 00000093", if_valid, if_rdata); end
    vecCount++; if (stall_f !== 1'b0) begin missCount++; $display("FAIL fetch_stall_c3 got %b want 0", stall_f); end
    if_req = 1'b0;
    tick();
    vecCount++; if (if_valid !== 1'b0 || mem_req !== 1'b0) begin missCount++; $display("FAIL fetch_single_pulse got valid %b req %b want 0 0", if_valid, mem_req); end
  endtask

  task automatic test_starvation();
    logic we; logic [31:0] addr; logic [31:0] wd;
    // Four DM grants with IF waiting; IF withdraws during each dm_valid cycle
    // so every arbitration sees both ports eligible.
    for (int k = 0; k < 4; k++) begin
      if_req = 1'b1; if_addr = 32'h0000_0300;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0400 + 32'(k * 4);
      serve(32'h0000_1000 + 32'(k), we, addr, wd);
      vecCount++; if (addr !== 32'h0000_0400 + 32'(k * 4) || we !== 1'b0) begin missCount++; $display("FAIL starve_dm_grant%0d got addr %h we %b want %h 0", k, addr, we, 32'h400 + 32'(k * 4)); end
      vecCount++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0000_1000 + 32'(k)) begin missCount++; $display("FAIL starve_dm_data%0d got %b %h want 1 %h", k, dm_valid, dm_rdata, 32'h1000 + 32'(k)); end
      if_req = 1'b0;
      tick();
    end
    if_req = 1'b1;
    serve(32'h0000_2222, we, addr, wd);
    vecCount++; if (addr !== 32'h0000_0300 || we !== 1'b0) begin missCount++; $display("FAIL starve_if_forced got addr %h we %b want 00000300 0", addr, we); end
    vecCount++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_2222 || dm_valid !== 1'b0) begin missCount++; $display("FAIL starve_if_data got %b %h dmv %b want 1 00002222 0", if_valid, if_rdata, dm_valid); end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h0000_0500;
    serve(32'h0000_4444, we, addr, wd);
    vecCount++; if (addr !== 32'h0000_0500) begin missCount++; $display("FAIL starve_cleared got addr %h want 00000500", addr); end
    vecCount++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0000_4444) begin missCount++; $display("FAIL starve_after_data got %b %h want 1 00004444", dm_valid, dm_rdata); end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    logic we; logic [31:0] addr; logic [31:0] wd;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'h0000_00AA;
    #1;
    vecCount++; if (stall_m !== 1'b1 || stall_f !== 1'b1) begin missCount++; $display("FAIL simul_stall_c0 got %b%b want 11", stall_f, stall_m); end
    serve(32'h5555_5555, we, addr, wd);
    vecCount++; if (we !== 1'b1 || addr !== 32'h0000_0100 || wd !== 32'h0000_00AA) begin missCount++; $display("FAIL simul_dm_first got we %b addr %h wd %h want 1 00000100 000000aa", we, addr, wd); end
    vecCount++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0000_4444 || stall_m !== 1'b0) begin missCount++; $display("FAIL simul_store_done got %b %h stall %b want 1 00004444 0", dm_valid, dm_rdata, stall_m); end
    dm_req = 1'b0; dm_we = 1'b0;
    serve(32'h0000_0013, we, addr, wd);
    vecCount++; if (we !== 1'b0 || addr !== 32'h0000_0200) begin missCount++; $display("FAIL simul_if_second got we %b addr %h want 0 00000200", we, addr); end
    vecCount++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_0013 || dm_valid !== 1'b0) begin missCount++; $display("FAIL simul_if_done got %b %h dmv %b want 1 00000013 0", if_valid, if_rdata, dm_valid); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_stray_rvalid();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    tick(); tick();
    vecCount++; if (if_valid !== 1'b0 || dm_valid !== 1'b0 || mem_req !== 1'b0) begin missCount++; $display("FAIL stray_idle got %b%b req %b want 000", if_valid, dm_valid, mem_req); end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0600;
    tick(); tick(); tick();
    vecCount++; if (mem_req !== 1'b1 || dm_valid !== 1'b0 || if_valid !== 1'b0) begin missCount++; $display("FAIL stray_issue got req %b valid %b%b want 1 00", mem_req, if_valid, dm_valid); end
    vecCount++; if (dm_rdata !== 32'h0000_4444 || if_rdata !== 32'h0000_0013) begin missCount++; $display("FAIL stray_rdata got %h %h want 00004444 00000013", dm_rdata, if_rdata); end
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0066;
    tick();
    mem_rvalid = 1'b0;
    vecCount++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0000_0066) begin missCount++; $display("FAIL stray_then_load got %b %h want 1 00000066", dm_valid, dm_rdata); end
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    logic we; logic [31:0] addr; logic [31:0] wd;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0700; mem_ready = 1'b0;
    tick();
    n = 1;
    while (mem_req === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    vecCount++; if (n - 1 !== 64) begin missCount++; $display("FAIL timeout_req_cycles got %0d want 64", n - 1); end
    vecCount++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin missCount++; $display("FAIL timeout_abort_data got %b %h want 1 deadbeef", dm_valid, dm_rdata); end
    vecCount++; if (mem_err !== 1'b1) begin missCount++; $display("FAIL timeout_err got %b want 1", mem_err); end
    dm_req = 1'b0;
    tick();
    vecCount++; if (dm_valid !== 1'b0) begin missCount++; $display("FAIL timeout_single_pulse got %b want 0", dm_valid); end
    if_req = 1'b1; if_addr = 32'h0000_0020;
    serve(32'h0000_0077, we, addr, wd);
    vecCount++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_0077) begin missCount++; $display("FAIL timeout_next_fetch got %b %h want 1 00000077", if_valid, if_rdata); end
    vecCount++; if (mem_err !== 1'b1) begin missCount++; $display("FAIL timeout_err_sticky got %b want 1", mem_err); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic we; logic [31:0] addr; logic [31:0] wd;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0800; mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    vecCount++; if (mem_req !== 1'b0 || mem_addr !== 32'h0000_0800) begin missCount++; $display("FAIL rstmid_in_wait got req %b addr %h want 0 00000800", mem_req, mem_addr); end
    rst = 1'b1; dm_req = 1'b0;
    #1;
    vecCount++; if (mem_addr !== 32'h0 || mem_err !== 1'b0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin missCount++; $display("FAIL rstmid_async got addr %h err %b rd %h %h want 0", mem_addr, mem_err, if_rdata, dm_rdata); end
    tick();
    vecCount++; if (dm_valid !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0) begin missCount++; $display("FAIL rstmid_no_pulse got %b%b req %b want 000", if_valid, dm_valid, mem_req); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0123;
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    vecCount++; if (dm_valid !== 1'b0 || dm_rdata !== 32'h0) begin missCount++; $display("FAIL rstmid_after got %b %h want 0 0", dm_valid, dm_rdata); end
    if_req = 1'b1; if_addr = 32'h0000_0040;
    serve(32'h0000_0099, we, addr, wd);
    vecCount++; if (addr !== 32'h0000_0040 || if_valid !== 1'b1 || if_rdata !== 32'h0000_0099) begin missCount++; $display("FAIL rstmid_fresh got addr %h %b %h want 00000040 1 00000099", addr, if_valid, if_rdata); end
    vecCount++; if (mem_err !== 1'b0) begin missCount++; $display("FAIL rstmid_err got %b want 0", mem_err); end
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_starvation();
    test_simultaneous();
    test_stray_rvalid();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
